// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash ownership arbiter.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    TO_PROG  = 2'd1,
    PROG_OWN = 2'd2,
    TO_CPU   = 2'd3
  } arb_state_e;

  localparam int GUARD_W = 8;

  localparam logic IDLE_CS   = 1'b1;
  localparam logic IDLE_CLK  = 1'b0;
  localparam logic IDLE_MOSI = 1'b0;

  // Guard counter starts at cycles-1 so that exactly 'cycles' idle clocks elapse.
  function automatic logic [GUARD_W-1:0] guard_load(input int unsigned cycles);
    return GUARD_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is a parameter.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_flash_arbiter.sv
// Guarded ownership arbiter between the 6809 ROM path and the FT2232 programmer.
// Optional CPU-starvation flag built only when SPI_ARB_STARVE_EN is defined.
//
// state    | meaning
// CPU_OWN  | flash pins mirror the CPU controller
// TO_PROG  | idle-bus guard before handing to the programmer
// PROG_OWN | flash pins mirror the FT2232 writer
// TO_CPU   | idle-bus guard before handing back to the CPU
module spi_flash_arbiter
  import spi_flash_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES  = 4,
  parameter logic [15:0] STARVE_CYCLES = 16'd3300
) (
  input  logic clk,
  input  logic reset,
  input  logic i_FT_CS,
  input  logic i_cpu_req,
  input  logic i_cpu_clk,
  input  logic i_cpu_mosi,
  input  logic i_cpu_cs,
  input  logic i_prog_clk,
  input  logic i_prog_mosi,
  input  logic i_prog_cs,
  output logic o_SPI_CLK,
  output logic o_SPI_MOSI,
  output logic o_SPI_CS,
  output logic o_cpu_grant,
  output logic o_prog_grant,
  output logic o_cpu_hold,
  output logic o_starve_err
);

  localparam logic [GUARD_W-1:0] GUARD_LOAD = guard_load(GUARD_CYCLES);

  arb_state_e         state_q, state_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               ft_cs_sync;
  logic               prog_req;

  sync_2ff #(.RESET_VAL(1'b1)) u_ft_cs_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (i_FT_CS),
    .q_o   (ft_cs_sync)
  );

  assign prog_req = ~ft_cs_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TO_CPU;
      guard_q <= GUARD_LOAD;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    guard_d = (guard_q != '0) ? guard_q - GUARD_W'(1) : guard_q;
    unique case (state_q)
      CPU_OWN: begin
        // i_cpu_cs is sampled here, so a frame that starts this cycle wins.
        if (prog_req && i_cpu_cs) begin
          state_d = TO_PROG;
          guard_d = GUARD_LOAD;
        end
      end
      TO_PROG: begin
        if (!prog_req) begin
          state_d = TO_CPU;
          guard_d = GUARD_LOAD;
        end else if (guard_q == '0) begin
          state_d = PROG_OWN;
        end
      end
      PROG_OWN: begin
        if (!prog_req) begin
          state_d = TO_CPU;
          guard_d = GUARD_LOAD;
        end
      end
      TO_CPU: begin
        if (guard_q == '0) begin
          state_d = CPU_OWN;
        end
      end
      default: begin
        state_d = TO_CPU;
        guard_d = GUARD_LOAD;
      end
    endcase
  end

  always_comb begin
    o_SPI_CS   = IDLE_CS;
    o_SPI_CLK  = IDLE_CLK;
    o_SPI_MOSI = IDLE_MOSI;
    if (state_q == CPU_OWN) begin
      o_SPI_CS   = i_cpu_cs;
      o_SPI_CLK  = i_cpu_clk;
      o_SPI_MOSI = i_cpu_mosi;
    end else if (state_q == PROG_OWN) begin
      o_SPI_CS   = i_prog_cs;
      o_SPI_CLK  = i_prog_clk;
      o_SPI_MOSI = i_prog_mosi;
    end
  end

  assign o_cpu_grant  = (state_q == CPU_OWN);
  assign o_prog_grant = (state_q == PROG_OWN);
  assign o_cpu_hold   = i_cpu_req & ~o_cpu_grant;

`ifdef SPI_ARB_STARVE_EN
  logic [15:0] starve_cnt_q, starve_cnt_d;
  logic        starve_err_q, starve_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      starve_err_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_err_q <= starve_err_d;
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    starve_err_d = starve_err_q;
    if (o_cpu_hold) begin
      starve_cnt_d = (starve_cnt_q != 16'hFFFF) ? starve_cnt_q + 16'd1 : starve_cnt_q;
      if (starve_cnt_d == STARVE_CYCLES) begin
        starve_err_d = 1'b1;
      end
    end
  end

  assign o_starve_err = starve_err_q;
`else
  // Keeps the limit parameter referenced in builds without the counter.
  assign o_starve_err = 1'b0 & (|STARVE_CYCLES);
`endif

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter; expected bus values go through a scoreboard queue.
module tb_spi_flash_arbiter;

  localparam int          GUARD  = 4;
  localparam logic [15:0] STARVE = 16'd10;

  logic clk = 1'b0;
  logic reset;
  logic i_FT_CS, i_cpu_req;
  logic i_cpu_clk, i_cpu_mosi, i_cpu_cs;
  logic i_prog_clk, i_prog_mosi, i_prog_cs;
  logic o_SPI_CLK, o_SPI_MOSI, o_SPI_CS;
  logic o_cpu_grant, o_prog_grant, o_cpu_hold, o_starve_err;

  int tests_run = 0;
  int fail_cnt  = 0;

  // {cs, clk, mosi}
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  spi_flash_arbiter #(.GUARD_CYCLES(GUARD), .STARVE_CYCLES(STARVE)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_FT_CS      (i_FT_CS),
    .i_cpu_req    (i_cpu_req),
    .i_cpu_clk    (i_cpu_clk),
    .i_cpu_mosi   (i_cpu_mosi),
    .i_cpu_cs     (i_cpu_cs),
    .i_prog_clk   (i_prog_clk),
    .i_prog_mosi  (i_prog_mosi),
    .i_prog_cs    (i_prog_cs),
    .o_SPI_CLK    (o_SPI_CLK),
    .o_SPI_MOSI   (o_SPI_MOSI),
    .o_SPI_CS     (o_SPI_CS),
    .o_cpu_grant  (o_cpu_grant),
    .o_prog_grant (o_prog_grant),
    .o_cpu_hold   (o_cpu_hold),
    .o_starve_err (o_starve_err)
  );

  function automatic logic starve_en();
`ifdef SPI_ARB_STARVE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [2:0] got;
    reset = 1'b1; i_FT_CS = 1'b1; i_cpu_req = 1'b0;
    i_cpu_cs = 1'b1; i_cpu_clk = 1'b1; i_cpu_mosi = 1'b1;
    i_prog_cs = 1'b0; i_prog_clk = 1'b1; i_prog_mosi = 1'b1;
    step(2);
    got = {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
    tests_run++;
    if (got !== 3'b100 || o_cpu_grant !== 1'b0 || o_prog_grant !== 1'b0 ||
        o_cpu_hold !== 1'b0 || o_starve_err !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_values bus=%b cg=%b pg=%b hold=%b err=%b required bus=100 all flags 0",
               got, o_cpu_grant, o_prog_grant, o_cpu_hold, o_starve_err);
    end
    reset = 1'b0;
    for (int i = 0; i < GUARD; i++) begin
      got = {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
      tests_run++;
      if (got !== 3'b100 || o_cpu_grant !== 1'b0) begin
        fail_cnt++;
        $display("FAIL reset_guard cycle=%0d bus=%b cg=%b required bus=100 cg=0", i, got, o_cpu_grant);
      end
      step(1);
    end
    got = {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
    tests_run++;
    if (o_cpu_grant !== 1'b1 || got !== 3'b111) begin
      fail_cnt++;
      $display("FAIL reset_to_cpu cg=%b bus=%b required cg=1 bus=111", o_cpu_grant, got);
    end
  endtask

  task automatic test_cpu_track();
    logic [2:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      i_cpu_cs = 1'($urandom); i_cpu_clk = 1'($urandom); i_cpu_mosi = 1'($urandom);
      i_prog_cs = 1'($urandom); i_prog_clk = 1'($urandom); i_prog_mosi = 1'($urandom);
      exp_q.push_back({i_cpu_cs, i_cpu_clk, i_cpu_mosi});
      #1;
      got = {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL cpu_track i=%0d got=%b required=%b", i, got, exp);
      end
      step(1);
    end
    i_cpu_req = 1'b1;
    #1;
    tests_run++;
    if (o_cpu_hold !== 1'b0) begin
      fail_cnt++;
      $display("FAIL cpu_hold_granted got=%b required=0", o_cpu_hold);
    end
    i_cpu_req = 1'b0; i_cpu_cs = 1'b1; i_cpu_clk = 1'b0; i_cpu_mosi = 1'b0;
    step(1);
  endtask

  task automatic test_prog_grant();
    logic [2:0] got, exp;
    i_prog_cs = 1'b0; i_prog_clk = 1'b1; i_prog_mosi = 1'b1;
    i_FT_CS = 1'b0;
    for (int i = 1; i <= 3 + GUARD; i++) begin
      step(1);
      got = {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
      tests_run++;
      if (i < 3 + GUARD) begin
        if (o_prog_grant !== 1'b0 || got !== 3'b100) begin
          fail_cnt++;
          $display("FAIL prog_gap edge=%0d pg=%b bus=%b required pg=0 bus=100", i, o_prog_grant, got);
        end
      end else if (o_prog_grant !== 1'b1 || got !== 3'b011) begin
        fail_cnt++;
        $display("FAIL prog_grant edge=%0d pg=%b bus=%b required pg=1 bus=011", i, o_prog_grant, got);
      end
    end
    for (int i = 0; i < 6; i++) begin
      i_prog_cs = 1'($urandom); i_prog_clk = 1'($urandom); i_prog_mosi = 1'($urandom);
      i_cpu_cs = 1'($urandom); i_cpu_clk = 1'($urandom); i_cpu_mosi = 1'($urandom);
      exp_q.push_back({i_prog_cs, i_prog_clk, i_prog_mosi});
      #1;
      got = {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fail_cnt++;
        $display("FAIL prog_track i=%0d got=%b required=%b", i, got, exp);
      end
      step(1);
    end
    i_cpu_cs = 1'b1; i_cpu_clk = 1'b0; i_cpu_mosi = 1'b0;
  endtask

  task automatic test_starve();
    logic exp;
    i_cpu_req = 1'b1; i_cpu_cs = 1'b0; i_prog_cs = 1'b1;
    #1;
    tests_run++;
    if (o_cpu_hold !== 1'b1 || o_SPI_CS !== 1'b1) begin
      fail_cnt++;
      $display("FAIL hold_in_prog hold=%b cs=%b required hold=1 cs=1", o_cpu_hold, o_SPI_CS);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1);
      exp = starve_en() && (i >= int'(STARVE));
      tests_run++;
      if (o_starve_err !== exp) begin
        fail_cnt++;
        $display("FAIL starve edge=%0d got=%b required=%b", i, o_starve_err, exp);
      end
    end
    i_cpu_cs = 1'b1;
  endtask

  task automatic test_return_to_cpu();
    i_FT_CS = 1'b1;
    for (int i = 1; i <= 3 + GUARD; i++) begin
      step(1);
      tests_run++;
      if (i < 3 + GUARD) begin
        if (o_cpu_grant !== 1'b0 || o_cpu_hold !== 1'b1) begin
          fail_cnt++;
          $display("FAIL return_gap edge=%0d cg=%b hold=%b required cg=0 hold=1", i, o_cpu_grant, o_cpu_hold);
        end
      end else if (o_cpu_grant !== 1'b1 || o_cpu_hold !== 1'b0 || o_starve_err !== starve_en()) begin
        fail_cnt++;
        $display("FAIL return_grant cg=%b hold=%b err=%b required cg=1 hold=0 err=%b",
                 o_cpu_grant, o_cpu_hold, o_starve_err, starve_en());
      end
    end
    i_cpu_req = 1'b0;
  endtask

  task automatic test_midframe();
    logic [2:0] got, exp;
    i_prog_cs = 1'b0; i_prog_clk = 1'b1; i_prog_mosi = 1'b1;
    i_cpu_cs = 1'b0;
    i_FT_CS = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_cpu_clk = 1'($urandom); i_cpu_mosi = 1'($urandom);
      exp_q.push_back({1'b0, i_cpu_clk, i_cpu_mosi});
      #1;
      got = {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp || o_prog_grant !== 1'b0) begin
        fail_cnt++;
        $display("FAIL midframe i=%0d got=%b pg=%b required=%b pg=0", i, got, o_prog_grant, exp);
      end
      step(1);
    end
    i_cpu_cs = 1'b1; i_cpu_clk = 1'b0; i_cpu_mosi = 1'b0;
    for (int i = 1; i <= 1 + GUARD; i++) begin
      step(1);
      tests_run++;
      if (o_prog_grant !== (i == 1 + GUARD)) begin
        fail_cnt++;
        $display("FAIL midframe_handover edge=%0d pg=%b required=%b", i, o_prog_grant, (i == 1 + GUARD));
      end
    end
  endtask

  task automatic test_async_reset();
    i_prog_cs = 1'b0;
    #1;
    tests_run++;
    if (o_SPI_CS !== 1'b0) begin
      fail_cnt++;
      $display("FAIL prog_frame_active cs=%b required=0", o_SPI_CS);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (o_SPI_CS !== 1'b1 || o_prog_grant !== 1'b0 || o_starve_err !== 1'b0) begin
      fail_cnt++;
      $display("FAIL async_reset cs=%b pg=%b err=%b required cs=1 pg=0 err=0",
               o_SPI_CS, o_prog_grant, o_starve_err);
    end
    step(2);
    reset = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_cpu_track();
    test_prog_grant();
    test_starve();
    test_return_to_cpu();
    test_midframe();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
